mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM-stage data-memory access unit between the EX/MEM register and the MEM_WB register.
//  Converts MemRead/MemWrite plus ALU address into a req/ack bus transaction with byte enables.
//  Aligns and extends load data, and drives Mem_Res into MEM_WB.
//  Holds the pipeline (stall_out) while a transaction is outstanding.
// PARAMETERS
//  TIMEOUT    16  max BUSY cycles without mem_ack before bus error (>=2)
//  ERR_DATA   32'h0  load result returned on timeout or misalignment
// PORTS
//  clk          in   1   pipeline clock, all state on rising edge
//  reset        in   1   async, active-low; one clock; reset is asynchronous and active-low
//  ALU_Res_in   in   32  effective address
//  bus_B_in     in   32  store data (rt)
//  MemRead_in   in   1   load request
//  MemWrite_in  in   1   store request
//  MemSize_in   in   2   00 word, 01 half, 10 byte, 11 reserved (treated as word)
//  MemSign_in   in   1   1 = sign-extend sub-word load, 0 = zero-extend
//  stall_in     in   1   MEM_WB cannot accept this cycle
//  mem_ack      in   1   bus completes transaction this cycle
//  mem_rdata    in   32  read data, valid with mem_ack
//  mem_req      out  1   registered; held high from issue until the ack cycle
//  mem_we       out  1   registered; write strobe qualified by mem_req
//  mem_addr     out  32  registered; word-aligned ({addr[31:2],2'b00})
//  mem_be       out  4   registered byte enables, little-endian
//  mem_wdata    out  32  registered; store data replicated across lanes
//  Mem_Res_out  out  32  registered load result to MEM_WB Mem_Res_in
//  stall_out    out  1   combinational; freeze PC/IF/ID/EX/EX-MEM
//  align_err    out  1   registered 1-cycle pulse: misaligned access dropped
//  bus_err      out  1   registered 1-cycle pulse: TIMEOUT expired
// BEHAVIOUR
//  Reset: state IDLE; all registered outputs 0; timeout counter 0.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: access = MemRead_in|MemWrite_in. Aligned access: stall_out=1; load mem_* regs; ->BUSY.
//     Misaligned (half addr[0]=1, word addr[1:0]!=0): no bus cycle; Mem_Res_out=ERR_DATA;
//     align_err=1 next cycle; stall_out=0; stay IDLE. Read and write both set: store wins.
//   BUSY: stall_out=1. On mem_ack: drop mem_req, capture aligned load data -> DONE.
//     Counter reaching TIMEOUT without ack: drop mem_req, Mem_Res_out=ERR_DATA, bus_err pulse -> DONE.
//   DONE: stall_out=stall_in; remain while stall_in=1; else ->IDLE. No re-issue of the held instruction.
//  Min latency: issue cycle + ack cycle + DONE = 3 cycles; Mem_Res_out valid throughout DONE.
//  Byte enables: word 1111; half addr[1]?1100:0011; byte 0001<<addr[1:0].
//  Store data: word as-is; half {2{b[15:0]}}; byte {4{b[7:0]}}.
//  Load: select lane by addr[1:0]; extend to 32 per MemSign_in; word ignores MemSign_in.
//  Stores: Mem_Res_out unchanged (don't-care to WB).
//  mem_ack outside BUSY is ignored. mem_ack in the TIMEOUT cycle counts as success.
//  Async reset mid-BUSY: mem_req drops immediately; the outstanding transaction is abandoned.
// STRUCTURE
//  Package mips_mem_pkg: MEM_SZ_WORD/HALF/BYTE encodings, state enum (IDLE/BUSY/DONE), BE constants.
//  Sub-module mem_load_align: combinational lane select plus sign/zero extension
//  (rdata, addr[1:0], size, sign -> 32b). FSM, counter and bus regs stay in the top.
// TESTING
//  SW addr 0x100 data 0x12345678, ack after 2 cycles -> mem_be=1111, wdata=0x12345678, stall 4 cycles.
//  LB signed addr 0x103, rdata 0x80FF_FF7F -> Mem_Res_out=0xFFFFFF80; LBU -> 0x00000080.
//  LH addr 0x101 -> no mem_req; align_err one cycle; Mem_Res_out=ERR_DATA; stall_out=0.
//  LW, ack never arrives, TIMEOUT=16 -> mem_req drops after 16 BUSY cycles; bus_err pulse; return to IDLE.
//  reset low in BUSY -> mem_req=0 immediately; late ack after reset release ignored; state IDLE.
//  LW done with stall_in=1 for 3 cycles -> DONE held; Mem_Res_out stable; single mem_req only.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings and helpers for the MEM-stage access unit
//
// Purpose : access-size encodings, FSM state type, byte-enable constants and
//           small pure helpers used by mem_access_stage.
// Contents: MEM_SZ_WORD/HALF/BYTE, mem_state_e (IDLE/BUSY/DONE), BE_* constants,
//           is_misaligned(), byte_enables(), store_lanes().

package mips_mem_pkg;

    localparam logic [1:0] MEM_SZ_WORD = 2'b00;
    localparam logic [1:0] MEM_SZ_HALF = 2'b01;
    localparam logic [1:0] MEM_SZ_BYTE = 2'b10;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mem_state_e;

    // The reserved size code 2'b11 falls into the word branch everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            MEM_SZ_HALF: bad = off[0];
            MEM_SZ_BYTE: bad = 1'b0;
            default:     bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            MEM_SZ_HALF: be = off[1] ? BE_HALF_HI : BE_HALF_LO;
            MEM_SZ_BYTE: be = BE_BYTE0 << off;
            default:     be = BE_WORD;
        endcase
        return be;
    endfunction

    // Sub-word store data is replicated so whichever lane the enables pick
    // already carries the right bits.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            MEM_SZ_HALF: lanes = {2{data[15:0]}};
            MEM_SZ_BYTE: lanes = {4{data[7:0]}};
            default:     lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load lane select and sign/zero extension
//
// Purpose : picks the addressed byte/halfword out of a 32-bit read word and
//           extends it to 32 bits. Purely combinational.
// Ports   : rdata_i [31:0] raw bus read data
//           off_i   [1:0]  byte offset of the access (addr[1:0])
//           size_i  [1:0]  access size encoding
//           sign_i         1 = sign-extend sub-word, 0 = zero-extend
//           data_o  [31:0] aligned, extended load result

module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            MEM_SZ_HALF: data_o = {{16{sign_i & half_sel[15]}}, half_sel};
            MEM_SZ_BYTE: data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            default:     data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage data-memory access unit with req/ack bus
//
// Purpose : turns MemRead/MemWrite plus the ALU address into a single req/ack
//           bus transaction, aligns load data into Mem_Res_out and stalls the
//           front of the pipeline while the transaction is outstanding.
// Ports   : clk, reset (async, active-low)
//           ALU_Res_in, bus_B_in, MemRead_in, MemWrite_in, MemSize_in, MemSign_in
//                                        - EX/MEM register fields
//           stall_in                     - MEM_WB cannot accept this cycle
//           mem_ack, mem_rdata           - bus response
//           mem_req, mem_we, mem_addr, mem_be, mem_wdata - registered bus request
//           Mem_Res_out                  - registered load result to MEM_WB
//           stall_out                    - combinational pipeline freeze
//           align_err, bus_err           - registered one-cycle error pulses

module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALU_Res_in,
    input  logic [31:0] bus_B_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  MemSize_in,
    input  logic        MemSign_in,
    input  logic        stall_in,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] Mem_Res_out,
    output logic        stall_out,
    output logic        align_err,
    output logic        bus_err
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [3:0]       mem_be_q;
    logic [31:0]      mem_wdata_q;
    logic [31:0]      mem_res_q;
    logic             align_err_q;
    logic             bus_err_q;

    // Shape of the outstanding load, kept because mem_addr is word-aligned.
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             sign_q;

    logic             access;
    logic             misaligned;
    logic [31:0]      load_data;

    assign access     = MemRead_in | MemWrite_in;
    assign misaligned = is_misaligned(MemSize_in, ALU_Res_in[1:0]);

    mem_load_align u_load_align (
        .rdata_i (mem_rdata),
        .off_i   (off_q),
        .size_i  (size_q),
        .sign_i  (sign_q),
        .data_o  (load_data)
    );

    // A misaligned access is dropped in the same cycle, so it never stalls.
    always_comb begin
        stall_out = 1'b0;
        case (state_q)
            IDLE:    stall_out = access & ~misaligned;
            BUSY:    stall_out = 1'b1;
            DONE:    stall_out = stall_in;
            default: stall_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            mem_res_q   <= '0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
        end else begin
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access) begin
                        if (misaligned) begin
                            mem_res_q   <= ERR_DATA;
                            align_err_q <= 1'b1;
                        end else begin
                            // Store wins when both strobes are set.
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= MemWrite_in;
                            mem_addr_q  <= {ALU_Res_in[31:2], 2'b00};
                            mem_be_q    <= byte_enables(MemSize_in, ALU_Res_in[1:0]);
                            mem_wdata_q <= store_lanes(MemSize_in, bus_B_in);
                            off_q       <= ALU_Res_in[1:0];
                            size_q      <= MemSize_in;
                            sign_q      <= MemSign_in;
                            cnt_q       <= '0;
                            state_q     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // Ack is checked first so an ack in the last allowed cycle succeeds.
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (!mem_we_q) begin
                            mem_res_q <= load_data;
                        end
                        state_q   <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_res_q <= ERR_DATA;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Leave only when MEM_WB takes the result; the held
                    // instruction is never re-issued.
                    if (!stall_in) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;
    assign Mem_Res_out = mem_res_q;
    assign align_err   = align_err_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage

module tb_mem_access_stage;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALU_Res_in;
    logic [31:0] bus_B_in;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic [1:0]  MemSize_in;
    logic        MemSign_in;
    logic        stall_in;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] Mem_Res_out;
    logic        stall_out;
    logic        align_err;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] track;
    int req_hi_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_req) req_hi_cnt++;

    mem_access_stage #(.TIMEOUT(16), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .ALU_Res_in(ALU_Res_in), .bus_B_in(bus_B_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemSize_in(MemSize_in), .MemSign_in(MemSign_in),
        .stall_in(stall_in), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .Mem_Res_out(Mem_Res_out),
        .stall_out(stall_out), .align_err(align_err), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] bdata;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] res;
        logic        align;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] bdata,
                                input logic rd, input logic wr, input logic [1:0] size,
                                input logic sign, input logic [31:0] rdata, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] res, input logic align);
        vec_t v;
        v.addr = addr; v.bdata = bdata; v.rd = rd; v.wr = wr; v.size = size; v.sign = sign;
        v.rdata = rdata; v.be = be; v.wdata = wdata; v.res = res; v.align = align;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] bdata, input logic rd,
                         input logic wr, input logic [1:0] size, input logic sign);
        ALU_Res_in = addr; bus_B_in = bdata; MemRead_in = rd; MemWrite_in = wr;
        MemSize_in = size; MemSign_in = sign;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        drive(v.addr, v.bdata, v.rd, v.wr, v.size, v.sign);
        #1;
        check($sformatf("vec%0d_issue_stall", i), {31'b0, stall_out}, {31'b0, ~v.align});
        @(posedge clk); #1;
        MemRead_in = 1'b0; MemWrite_in = 1'b0;
        if (v.align) begin
            track = ERR;
            check($sformatf("vec%0d_align_err", i), {31'b0, align_err}, 32'd1);
            check($sformatf("vec%0d_no_req", i), {31'b0, mem_req}, 32'd0);
            check($sformatf("vec%0d_err_res", i), Mem_Res_out, track);
            @(posedge clk); #1;
            check($sformatf("vec%0d_align_pulse_end", i), {31'b0, align_err}, 32'd0);
        end else begin
            check($sformatf("vec%0d_req", i), {31'b0, mem_req}, 32'd1);
            check($sformatf("vec%0d_we", i), {31'b0, mem_we}, {31'b0, v.wr});
            check($sformatf("vec%0d_addr", i), mem_addr, v.addr & 32'hFFFF_FFFC);
            check($sformatf("vec%0d_be", i), {28'b0, mem_be}, {28'b0, v.be});
            if (v.wr) check($sformatf("vec%0d_wdata", i), mem_wdata, v.wdata);
            mem_rdata = v.rdata; mem_ack = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (!v.wr) track = v.res;
            check($sformatf("vec%0d_req_drop", i), {31'b0, mem_req}, 32'd0);
            check($sformatf("vec%0d_done_stall", i), {31'b0, stall_out}, 32'd0);
            check($sformatf("vec%0d_res", i), Mem_Res_out, track);
            @(posedge clk); #1;
        end
    endtask

    // LW with an ack at BUSY cycle ack_at (1-based), or never when ack_at < 0.
    task automatic run_timeout(input string tag, input logic [31:0] addr, input int ack_at,
                               input logic [31:0] rdata);
        int n_req = 0;
        int n_bus = 0;
        int bus_at = -1;
        drive(addr, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0);
        mem_rdata = rdata;
        for (int c = 0; c < 20; c++) begin
            mem_ack = (c == ack_at);
            #1;
            if (mem_req) n_req++;
            if (bus_err) begin n_bus++; bus_at = c; end
            @(posedge clk); #1;
            MemRead_in = 1'b0;
        end
        mem_ack = 1'b0;
        check({tag, "_req_cycles"}, n_req, 16);
        if (ack_at < 0) begin
            track = ERR;
            check({tag, "_bus_err_count"}, n_bus, 1);
            check({tag, "_bus_err_cycle"}, bus_at, 17);
        end else begin
            track = rdata;
            check({tag, "_bus_err_count"}, n_bus, 0);
        end
        check({tag, "_res"}, Mem_Res_out, track);
        check({tag, "_idle_stall"}, {31'b0, stall_out}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n_stall;
        int n_req;

        reset = 1'b0; stall_in = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);

        vecs[0]  = mk(32'h100, 32'h1234_5678, 0, 1, 2'b00, 0, 32'h0,         4'b1111, 32'h1234_5678, 32'h0,         0);
        vecs[1]  = mk(32'h102, 32'hAAAA_BEEF, 0, 1, 2'b01, 0, 32'h0,         4'b1100, 32'hBEEF_BEEF, 32'h0,         0);
        vecs[2]  = mk(32'h100, 32'hAAAA_BEEF, 0, 1, 2'b01, 0, 32'h0,         4'b0011, 32'hBEEF_BEEF, 32'h0,         0);
        vecs[3]  = mk(32'h101, 32'h0000_00A5, 0, 1, 2'b10, 0, 32'h0,         4'b0010, 32'hA5A5_A5A5, 32'h0,         0);
        vecs[4]  = mk(32'h103, 32'h1234_56C3, 0, 1, 2'b10, 0, 32'h0,         4'b1000, 32'hC3C3_C3C3, 32'h0,         0);
        vecs[5]  = mk(32'h103, 32'h0,         1, 0, 2'b10, 1, 32'h80FF_FF7F, 4'b1000, 32'h0,         32'hFFFF_FF80, 0);
        vecs[6]  = mk(32'h103, 32'h0,         1, 0, 2'b10, 0, 32'h80FF_FF7F, 4'b1000, 32'h0,         32'h0000_0080, 0);
        vecs[7]  = mk(32'h100, 32'h0,         1, 0, 2'b10, 1, 32'h80FF_FF7F, 4'b0001, 32'h0,         32'h0000_007F, 0);
        vecs[8]  = mk(32'h102, 32'h0,         1, 0, 2'b10, 1, 32'h80FF_FF7F, 4'b0100, 32'h0,         32'hFFFF_FFFF, 0);
        vecs[9]  = mk(32'h102, 32'h0,         1, 0, 2'b01, 1, 32'h8001_1234, 4'b1100, 32'h0,         32'hFFFF_8001, 0);
        vecs[10] = mk(32'h100, 32'h0,         1, 0, 2'b01, 0, 32'h8001_F234, 4'b0011, 32'h0,         32'h0000_F234, 0);
        vecs[11] = mk(32'h100, 32'h0,         1, 0, 2'b01, 1, 32'h8001_F234, 4'b0011, 32'h0,         32'hFFFF_F234, 0);
        vecs[12] = mk(32'h104, 32'h0,         1, 0, 2'b00, 1, 32'h8765_4321, 4'b1111, 32'h0,         32'h8765_4321, 0);
        vecs[13] = mk(32'h101, 32'h0,         1, 0, 2'b01, 1, 32'h0,         4'b0000, 32'h0,         32'h0,         1);
        vecs[14] = mk(32'h102, 32'h0,         1, 0, 2'b00, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         1);
        vecs[15] = mk(32'h103, 32'h1111_2222, 0, 1, 2'b00, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         1);
        vecs[16] = mk(32'h108, 32'h55AA_55AA, 1, 1, 2'b00, 0, 32'h7777_7777, 4'b1111, 32'h55AA_55AA, 32'h0,         0);
        vecs[17] = mk(32'h10C, 32'h0,         1, 0, 2'b11, 1, 32'h1122_3344, 4'b1111, 32'h0,         32'h1122_3344, 0);
        vecs[18] = mk(32'h10E, 32'h0,         1, 0, 2'b11, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         1);

        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_be", {28'b0, mem_be}, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_res", Mem_Res_out, 32'h0);
        check("rst_align_err", {31'b0, align_err}, 32'd0);
        check("rst_bus_err", {31'b0, bus_err}, 32'd0);
        check("rst_stall", {31'b0, stall_out}, 32'd0);
        track = 32'h0;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) run_vec(i);

        // SW, ack two cycles after mem_req rises: four stalled cycles.
        drive(32'h100, 32'h1234_5678, 1'b0, 1'b1, 2'b00, 1'b0);
        n_stall = 0; n_req = 0;
        for (int c = 0; c < 6; c++) begin
            mem_ack = (c == 3);
            #1;
            if (stall_out) n_stall++;
            if (mem_req) n_req++;
            if (c == 1) begin
                check("sw_be", {28'b0, mem_be}, 32'hF);
                check("sw_wdata", mem_wdata, 32'h1234_5678);
            end
            @(posedge clk); #1;
            MemWrite_in = 1'b0;
        end
        mem_ack = 1'b0;
        check("sw_stall_cycles", n_stall, 4);
        check("sw_req_cycles", n_req, 3);

        // Ack in the final allowed BUSY cycle succeeds, then a full timeout.
        run_timeout("ack_last", 32'h204, 16, 32'h0BAD_CAFE);
        run_timeout("timeout", 32'h200, -1, 32'h0);

        // Async reset while BUSY, then a stray ack after release.
        drive(32'h300, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0);
        @(posedge clk); #1;
        MemRead_in = 1'b0;
        check("rstbusy_req_before", {31'b0, mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        track = 32'h0;
        check("rstbusy_req_drop", {31'b0, mem_req}, 32'd0);
        check("rstbusy_stall", {31'b0, stall_out}, 32'd0);
        check("rstbusy_res", Mem_Res_out, track);
        #2 reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("late_ack_req", {31'b0, mem_req}, 32'd0);
        check("late_ack_stall", {31'b0, stall_out}, 32'd0);
        check("late_ack_res", Mem_Res_out, track);
        check("late_ack_bus_err", {31'b0, bus_err}, 32'd0);
        @(posedge clk); #1;

        // LW completes while MEM_WB is blocked for three cycles.
        req_hi_cnt = 0;
        drive(32'h400, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0);
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; stall_in = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        track = 32'hCAFE_F00D;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("hold%0d_stall", k), {31'b0, stall_out}, 32'd1);
            check($sformatf("hold%0d_res", k), Mem_Res_out, track);
            check($sformatf("hold%0d_req", k), {31'b0, mem_req}, 32'd0);
            @(posedge clk); #1;
        end
        stall_in = 1'b0;
        #1;
        check("hold_release_stall", {31'b0, stall_out}, 32'd0);
        @(posedge clk); #1;
        MemRead_in = 1'b0;
        #1;
        check("hold_idle_stall", {31'b0, stall_out}, 32'd0);
        check("hold_idle_res", Mem_Res_out, track);
        @(posedge clk); #1;
        check("hold_single_req", req_hi_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
